// File: rtl/int_service_seq_if.sv
// Interrupt responder bus: controller handshake plus PC/fetch control.
interface int_service_seq_if #(
    parameter int pcWidth = 16
);
    logic               intPending;
    logic [pcWidth-1:0] isrAddr;
    logic               intEnable;
    logic               instrBoundary;
    logic [pcWidth-1:0] curPC;
    logic               retiReq;
    logic               intDisable;
    logic               clrPend;
    logic               pcLoad;
    logic [pcWidth-1:0] pcOut;
    logic               stall;
    logic               inISR;
    logic [2:0]         nestDepth;
    logic               retiErr;

    modport master (
        output intPending, isrAddr, intEnable, instrBoundary,
        output curPC, retiReq,
        input  intDisable, clrPend, pcLoad, pcOut, stall,
        input  inISR, nestDepth, retiErr
    );

    modport slave (
        input  intPending, isrAddr, intEnable, instrBoundary,
        input  curPC, retiReq,
        output intDisable, clrPend, pcLoad, pcOut, stall,
        output inISR, nestDepth, retiErr
    );
endinterface

// File: rtl/int_service_seq.sv
// CPU-side interrupt entry/return sequencer with saved-PC stack.
// Define NESTED_INT_EN for a stackDepth-entry stack allowing nested ISRs.
module int_service_seq #(
    parameter int pcWidth    = 16,
    parameter int stackDepth = 4
) (
    input logic              clk,
    input logic              clr,
    int_service_seq_if.slave bus
);

`ifdef NESTED_INT_EN
    localparam int depthMax = stackDepth;
    localparam bit nestOn   = 1'b1;
`else
    localparam int depthMax = (stackDepth < 1) ? stackDepth : 1;
    localparam bit nestOn   = 1'b0;
`endif

    // At least two slots so the pointer is never a zero-width slice
    localparam int stackSize = (depthMax < 2) ? 2 : depthMax;
    localparam int idxW      = $clog2(stackSize);

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        VECTOR,
        INISR,
        RETURN
    } stateT;

    stateT              state;
    logic [2:0]         depth;
    logic [2:0]         depthDec;
    logic [pcWidth-1:0] vecReg;
    logic [pcWidth-1:0] stack [stackSize];
    logic [idxW-1:0]    pushIdx;
    logic [idxW-1:0]    popIdx;
    logic               accept;

    assign depthDec = depth - 3'd1;
    assign pushIdx  = depth[idxW-1:0];
    assign popIdx   = depthDec[idxW-1:0];
    assign accept   = bus.intPending & bus.intEnable
                    & bus.instrBoundary & ~bus.intDisable;

    assign bus.nestDepth = depth;
    assign bus.inISR     = (depth != 3'd0);

    // Mask to present while sitting in INISR at depth d
    function automatic logic isrMask(input logic [2:0] d);
        return nestOn ? (d == 3'(depthMax)) : 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (clr) begin
            state          <= IDLE;
            depth          <= 3'd0;
            vecReg         <= '0;
            bus.intDisable <= 1'b0;
            bus.clrPend    <= 1'b0;
            bus.pcLoad     <= 1'b0;
            bus.pcOut      <= '0;
            bus.stall      <= 1'b0;
            bus.retiErr    <= 1'b0;
        end else begin
            bus.clrPend <= 1'b0;
            bus.pcLoad  <= 1'b0;
            bus.retiErr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        stack[pushIdx] <= bus.curPC;
                        vecReg         <= bus.isrAddr;
                        depth          <= depth + 3'd1;
                        state          <= ACK;
                        bus.clrPend    <= 1'b1;
                        bus.stall      <= 1'b1;
                        bus.intDisable <= 1'b1;
                    end else if (bus.retiReq) begin
                        bus.retiErr <= 1'b1;
                    end
                end
                ACK: begin
                    state          <= VECTOR;
                    bus.pcLoad     <= 1'b1;
                    bus.pcOut      <= vecReg;
                    bus.stall      <= 1'b1;
                    bus.intDisable <= 1'b1;
                end
                VECTOR: begin
                    state          <= INISR;
                    bus.stall      <= 1'b0;
                    bus.intDisable <= isrMask(depth);
                end
                INISR: begin
                    // RETI outranks a simultaneous accept; pending stays set
                    if (bus.retiReq) begin
                        state          <= RETURN;
                        bus.pcLoad     <= 1'b1;
                        bus.pcOut      <= stack[popIdx];
                        bus.stall      <= 1'b1;
                        bus.intDisable <= 1'b1;
`ifdef NESTED_INT_EN
                    end else if (accept) begin
                        stack[pushIdx] <= bus.curPC;
                        vecReg         <= bus.isrAddr;
                        depth          <= depth + 3'd1;
                        state          <= ACK;
                        bus.clrPend    <= 1'b1;
                        bus.stall      <= 1'b1;
                        bus.intDisable <= 1'b1;
`endif
                    end
                end
                RETURN: begin
                    depth     <= depthDec;
                    bus.stall <= 1'b0;
                    if (depthDec != 3'd0) begin
                        state          <= INISR;
                        bus.intDisable <= isrMask(depthDec);
                    end else begin
                        state          <= IDLE;
                        bus.intDisable <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.stall      <= 1'b0;
                    bus.intDisable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_service_seq.sv
// Bench for int_service_seq: vector table, corner sequences, random vs model.
module tb_int_service_seq;

    localparam int PW = 16;
    localparam int SD = 2;
`ifdef NESTED_INT_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    int_service_seq_if #(.pcWidth(PW)) bus ();

    int_service_seq #(
        .pcWidth(PW),
        .stackDepth(SD)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic clr, pend, en, bnd, reti;
        logic [15:0] cur, isr;
        logic chk;
        logic cp, pl, st, dis;
        logic [2:0] dep;
        logic re;
        logic chkPc;
        logic [15:0] po;
    } vecT;

    typedef struct {
        logic cp, pl, re, pop;
        logic [15:0] po;
    } slotT;

    vecT vecs[14];
    slotT ring[4];
    slotT zeroSlot;
    logic [15:0] savedQ[$];
    int busyUntil;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic setIn(input logic c, input logic p, input logic e,
                         input logic b, input logic r,
                         input logic [15:0] cur, input logic [15:0] isr);
        clr               = c;
        bus.intPending    = p;
        bus.intEnable     = e;
        bus.instrBoundary = b;
        bus.retiReq       = r;
        bus.curPC         = cur;
        bus.isrAddr       = isr;
    endtask

    function automatic vecT mk(
        input logic c, input logic p, input logic e, input logic b,
        input logic r, input logic [15:0] cur, input logic [15:0] isr,
        input logic k, input logic cp, input logic pl, input logic st,
        input logic dis, input logic [2:0] dep, input logic re,
        input logic kp, input logic [15:0] po);
        vecT v;
        v.clr = c; v.pend = p; v.en = e; v.bnd = b; v.reti = r;
        v.cur = cur; v.isr = isr; v.chk = k;
        v.cp = cp; v.pl = pl; v.st = st; v.dis = dis;
        v.dep = dep; v.re = re; v.chkPc = kp; v.po = po;
        return v;
    endfunction

    function automatic logic [8:0] ctlAct();
        return {bus.clrPend, bus.pcLoad, bus.stall, bus.intDisable,
                bus.inISR, bus.retiErr, bus.nestDepth};
    endfunction

    function automatic logic expDis(input int jj);
        if (jj < busyUntil) return 1'b1;
        if (savedQ.size() == 0) return 1'b0;
        return NEST ? (savedQ.size() == SD) : 1'b1;
    endfunction

    initial begin
        logic nd;
        int j;
        logic rClr, rPend, rEn, rBnd, rReti;
        logic [15:0] rCur, rIsr;
        logic [8:0] expBits;

        nd = ~NEST;
        zeroSlot = '{cp: 1'b0, pl: 1'b0, re: 1'b0, pop: 1'b0, po: 16'h0};
        setIn(1, 0, 0, 0, 0, 16'h0, 16'h0);

        vecs[0]  = mk(1,0,0,0,0,16'h0000,16'h0000, 0, 0,0,0,0,0,0, 0,16'h0);
        vecs[1]  = mk(0,0,1,0,0,16'h0000,16'h0000, 1, 0,0,0,0,0,0, 1,16'h0);
        vecs[2]  = mk(0,1,1,1,0,16'h0040,16'h0100, 1, 0,0,0,0,0,0, 0,16'h0);
        vecs[3]  = mk(0,0,1,0,0,16'h0040,16'h0100, 1, 1,0,1,1,1,0, 0,16'h0);
        vecs[4]  = mk(0,0,1,0,0,16'h0040,16'h0100, 1, 0,1,1,1,1,0, 1,16'h0100);
        vecs[5]  = mk(0,0,1,1,1,16'h0044,16'h0100, 1, 0,0,0,nd,1,0, 0,16'h0);
        vecs[6]  = mk(0,0,1,0,0,16'h0044,16'h0100, 1, 0,1,1,1,1,0, 1,16'h0040);
        vecs[7]  = mk(0,0,1,1,1,16'h0040,16'h0000, 1, 0,0,0,0,0,0, 0,16'h0);
        vecs[8]  = mk(0,0,1,0,0,16'h0040,16'h0000, 1, 0,0,0,0,0,1, 0,16'h0);
        vecs[9]  = mk(0,1,1,1,0,16'h1234,16'h2000, 1, 0,0,0,0,0,0, 0,16'h0);
        vecs[10] = mk(0,0,1,0,0,16'h1234,16'h2000, 1, 1,0,1,1,1,0, 0,16'h0);
        vecs[11] = mk(1,0,1,0,0,16'h1234,16'h2000, 1, 0,1,1,1,1,0, 1,16'h2000);
        vecs[12] = mk(0,0,1,0,0,16'h0000,16'h0000, 1, 0,0,0,0,0,0, 1,16'h0);
        vecs[13] = mk(0,0,1,0,0,16'h0000,16'h0000, 1, 0,0,0,0,0,0, 0,16'h0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].chk) begin
                chk($sformatf("vec%0d.ctl", i), ctlAct(),
                    {vecs[i].cp, vecs[i].pl, vecs[i].st, vecs[i].dis,
                     vecs[i].dep != 3'd0, vecs[i].re, vecs[i].dep});
                if (vecs[i].chkPc)
                    chk($sformatf("vec%0d.pcOut", i), bus.pcOut, vecs[i].po);
            end
            setIn(vecs[i].clr, vecs[i].pend, vecs[i].en, vecs[i].bnd,
                  vecs[i].reti, vecs[i].cur, vecs[i].isr);
            step();
        end

        // masked interrupt for 20 cycles
        setIn(0, 1, 0, 1, 0, 16'h0080, 16'h0900);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("mask", {bus.clrPend, bus.pcLoad, bus.stall}, 3'b000);
        end

        // RETI beats a simultaneous pending interrupt
        setIn(0, 1, 1, 1, 0, 16'h0040, 16'h0300);
        step();
        chk("prio.clrPend1", bus.clrPend, 1);
        bus.intPending = 0;
        step();
        chk("prio.vecPc", {bus.pcLoad, bus.pcOut}, {1'b1, 16'h0300});
        step();
        chk("prio.depth", bus.nestDepth, 1);
        bus.intPending = 1;
        bus.retiReq = 1;
        step();
        chk("prio.retPc", {bus.pcLoad, bus.pcOut}, {1'b1, 16'h0040});
        chk("prio.noClr", bus.clrPend, 0);
        bus.intPending = 0;
        bus.retiReq = 0;
        step();
        chk("prio.idle", {bus.clrPend, bus.nestDepth}, 4'h0);

        // nesting
        setIn(0, 1, 1, 1, 0, 16'h0010, 16'h0400);
        step();
        chk("nest1.clrPend", bus.clrPend, 1);
        bus.intPending = 0;
        step();
        chk("nest1.vecPc", {bus.pcLoad, bus.pcOut}, {1'b1, 16'h0400});
        step();
        chk("nest1.depth", bus.nestDepth, 1);
        setIn(0, 1, 1, 1, 0, 16'h0200, 16'h0500);
        step();
`ifdef NESTED_INT_EN
        chk("nest2.clrPend", bus.clrPend, 1);
        bus.intPending = 0;
        step();
        chk("nest2.vecPc", {bus.pcLoad, bus.pcOut}, {1'b1, 16'h0500});
        step();
        chk("nest2.depthDis", {bus.nestDepth, bus.intDisable}, {3'd2, 1'b1});
        bus.intPending = 1;
        bus.isrAddr = 16'h0600;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nest3.ignored", {bus.clrPend, bus.nestDepth}, {1'b0, 3'd2});
        end
        bus.intPending = 0;
        bus.retiReq = 1;
        step();
        chk("nest.ret1", {bus.pcLoad, bus.pcOut}, {1'b1, 16'h0200});
        bus.retiReq = 0;
        step();
        chk("nest.mid", {bus.nestDepth, bus.intDisable}, {3'd1, 1'b0});
        bus.retiReq = 1;
        step();
        chk("nest.ret2", {bus.pcLoad, bus.pcOut}, {1'b1, 16'h0010});
        bus.retiReq = 0;
        step();
        chk("nest.end", bus.nestDepth, 0);
`else
        for (int i = 0; i < 3; i++) begin
            chk("nest2.blocked", {bus.clrPend, bus.intDisable}, 2'b01);
            step();
        end
        bus.retiReq = 1;
        step();
        chk("nest.ret1", {bus.pcLoad, bus.pcOut}, {1'b1, 16'h0010});
        bus.retiReq = 0;
        step();
        chk("nest.idle", {bus.nestDepth, bus.clrPend}, 4'h0);
        step();
        chk("nest2.late", bus.clrPend, 1);
        bus.intPending = 0;
        step();
        chk("nest2.vecPc", {bus.pcLoad, bus.pcOut}, {1'b1, 16'h0500});
        step();
        bus.retiReq = 1;
        step();
        chk("nest.ret2", {bus.pcLoad, bus.pcOut}, {1'b1, 16'h0200});
        bus.retiReq = 0;
        step();
        chk("nest.end", bus.nestDepth, 0);
`endif

        // random traffic against an event-scheduling model
        setIn(1, 0, 0, 0, 0, 16'h0, 16'h0);
        step();
        clr = 0;
        savedQ.delete();
        for (int k = 0; k < 4; k++) ring[k] = zeroSlot;
        busyUntil = 0;
        j = 0;
        for (int n = 0; n < 3000; n++) begin
            int s;
            s = j % 4;
            if (ring[s].pop) void'(savedQ.pop_back());
            expBits = {ring[s].cp, ring[s].pl, 1'(j < busyUntil), expDis(j),
                       1'(savedQ.size() != 0), ring[s].re,
                       3'(savedQ.size())};
            chk("rand.ctl", ctlAct(), expBits);
            if (ring[s].pl) chk("rand.pcOut", bus.pcOut, ring[s].po);
            ring[s] = zeroSlot;

            rClr  = ($urandom_range(0, 49) == 0);
            rPend = 1'($urandom_range(0, 1));
            rEn   = ($urandom_range(0, 9) != 0);
            rBnd  = ($urandom_range(0, 9) < 7);
            rReti = ($urandom_range(0, 9) < 2);
            rCur  = 16'($urandom);
            rIsr  = 16'($urandom);
            setIn(rClr, rPend, rEn, rBnd, rReti, rCur, rIsr);

            if (rClr) begin
                savedQ.delete();
                for (int k = 0; k < 4; k++) ring[k] = zeroSlot;
                busyUntil = 0;
            end else if (j >= busyUntil) begin
                if (savedQ.size() != 0 && rReti) begin
                    ring[(j + 1) % 4].pl  = 1'b1;
                    ring[(j + 1) % 4].po  = savedQ[$];
                    ring[(j + 2) % 4].pop = 1'b1;
                    busyUntil = j + 2;
                end else if (rPend && rEn && rBnd && !expDis(j)) begin
                    savedQ.push_back(rCur);
                    ring[(j + 1) % 4].cp = 1'b1;
                    ring[(j + 2) % 4].pl = 1'b1;
                    ring[(j + 2) % 4].po = rIsr;
                    busyUntil = j + 3;
                end else if (savedQ.size() == 0 && rReti) begin
                    ring[(j + 1) % 4].re = 1'b1;
                end
            end
            step();
            j++;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
